// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//   Receive-side deserializer for one PHY lane, clocked at the bit rate.
//   It hunts bit by bit for the COMMA idle symbol and then checks for it at
//   every byte boundary. After LOCK_COUNT aligned COMMAs it declares the lane
//   active and from then on delivers each received byte. Only reset takes the
//   lane out of the active state.
//
// Ports
//   clk_8f    in   1      bit-rate clock, rising edge
//   reset_L   in   1      synchronous active-low reset
//   data_in   in   1      serial bit, MSB of each byte first
//   data_out  out  WIDTH  recovered byte (registered, held for WIDTH cycles)
//   valid_out out  1      data_out holds a non-COMMA byte received while active
//   active    out  1      lane aligned and locked
module serial_to_parallel_rx #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_8f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LCW = $clog2(LOCK_COUNT) + 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  // lock_cnt + 1 == LOCK_COUNT is tested as lock_cnt == LOCK_COUNT - 1
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LOCKING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t           state_r,    state_nxt_s;
  logic [WIDTH-1:0] sr_r;
  logic [BCW-1:0]   bit_cnt_r,  bit_cnt_nxt_s;
  logic [LCW-1:0]   lock_cnt_r, lock_cnt_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;
  logic             valid_nxt_s;
  logic             active_nxt_s;

  logic [WIDTH-1:0] win_s;
  logic             is_comma_s;
  logic             boundary_s;

  // Window including the bit sampled at this edge; all decisions use it.
  always_comb begin
    win_s      = {sr_r[WIDTH-2:0], data_in};
    is_comma_s = (win_s == COMMA);
    boundary_s = (state_r != ST_SEARCH) && (bit_cnt_r == BIT_LAST);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    data_nxt_s     = data_out;
    valid_nxt_s    = valid_out;
    active_nxt_s   = active;
    if (bit_cnt_r == BIT_LAST) begin
      bit_cnt_nxt_s = '0;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
    end

    case (state_r)
      ST_SEARCH: begin
        valid_nxt_s  = 1'b0;
        active_nxt_s = 1'b0;
        if (is_comma_s) begin
          // Comma found at an arbitrary bit offset: this edge is a boundary.
          bit_cnt_nxt_s  = '0;
          lock_cnt_nxt_s = LCW'(1);
          state_nxt_s    = ST_LOCKING;
        end else begin
          state_nxt_s    = ST_SEARCH;
        end
      end
      ST_LOCKING: begin
        if (boundary_s) begin
          if (is_comma_s) begin
            if (lock_cnt_r == LOCK_LAST) begin
              state_nxt_s  = ST_ACTIVE;
              active_nxt_s = 1'b1;
              valid_nxt_s  = 1'b0;
            end else begin
              lock_cnt_nxt_s = lock_cnt_r + LCW'(1);
            end
          end else begin
            // Lost alignment; hunting restarts with the next bit.
            lock_cnt_nxt_s = '0;
            state_nxt_s    = ST_SEARCH;
          end
        end else begin
          state_nxt_s = ST_LOCKING;
        end
      end
      ST_ACTIVE: begin
        if (boundary_s) begin
          data_nxt_s  = win_s;
          valid_nxt_s = !is_comma_s;
        end else begin
          data_nxt_s  = data_out;
        end
      end
      default: begin
        state_nxt_s    = ST_SEARCH;
        lock_cnt_nxt_s = '0;
        valid_nxt_s    = 1'b0;
        active_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      sr_r       <= '0;
      bit_cnt_r  <= '0;
      lock_cnt_r <= '0;
      state_r    <= ST_SEARCH;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active     <= 1'b0;
    end else begin
      sr_r       <= win_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      state_r    <= state_nxt_s;
      data_out   <= data_nxt_s;
      valid_out  <= valid_nxt_s;
      active     <= active_nxt_s;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx
//   Drives serial bits into serial_to_parallel_rx, predicts the per-cycle
//   outputs from a bit-history reference model and checks them in an
//   independent monitor through a queue.
module tb_serial_to_parallel_rx;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;

  logic       clk_8f = 1'b1;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       a;
  } exp_t;

  exp_t exp_q[$];

  serial_to_parallel_rx #(
    .WIDTH(8), .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk_8f(clk_8f), .reset_L(reset_L), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  always #5 clk_8f = ~clk_8f;

  // Reference model: all bits since the last reset, the index of the edge
  // where a comma was first seen, and how many aligned commas followed.
  bit         hist[$];
  bit         anchored = 1'b0;
  int         anchor = 0;
  int         cnt = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;

  task automatic model_step(input bit rst_l, input bit b);
    int n;
    logic [7:0] w;
    exp_t e;
    if (!rst_l) begin
      hist.delete();
      anchored = 1'b0;
      cnt      = 0;
      m_data   = 8'h00;
      m_valid  = 1'b0;
      m_active = 1'b0;
    end else begin
      hist.push_back(b);
      n = hist.size() - 1;
      w = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (n - k >= 0) w[k] = hist[n - k];
      end
      if (!anchored) begin
        if (w == COMMA) begin
          anchored = 1'b1;
          anchor   = n;
          cnt      = 1;
        end
      end else if ((n - anchor) % 8 == 0) begin
        if (m_active) begin
          m_data  = w;
          m_valid = (w != COMMA);
        end else if (w == COMMA) begin
          cnt++;
          if (cnt == LOCK_COUNT) m_active = 1'b1;
        end else begin
          anchored = 1'b0;
          cnt      = 0;
        end
      end
    end
    e.d = m_data;
    e.v = m_valid;
    e.a = m_active;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst_l, input bit b);
    @(negedge clk_8f);
    reset_L = rst_l;
    data_in = b;
    model_step(rst_l, b);
  endtask

  task automatic send_bit(input bit b);
    drive(1'b1, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(COMMA);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(1, 0)));
  endtask

  // Monitor: one expectation per clock edge, compared after the edge.
  initial begin
    exp_t e;
    int   edge_no;
    edge_no = 0;
    forever begin
      @(posedge clk_8f);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (data_out !== e.d || valid_out !== e.v || active !== e.a) begin
          n_err++;
          $display("FAIL outputs edge=%0d: got data=%h valid=%b active=%b, expected data=%h valid=%b active=%b",
                   edge_no, data_out, valid_out, active, e.d, e.v, e.a);
        end
        n_cmp++;
        if (valid_out === 1'b1 && active !== 1'b1) begin
          n_err++;
          $display("FAIL valid_implies_active edge=%0d: got valid=%b active=%b, expected active=1",
                   edge_no, valid_out, active);
        end
        edge_no++;
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int nb;
    do_reset(4);
    send_commas(4);
    send_byte(8'hDD); send_byte(8'hEC); send_byte(8'hAC);
    send_byte(8'hAA); send_byte(COMMA); send_byte(8'h99);
    send_bit(1'b1); send_bit(1'b0);          // misalign in ACTIVE: ignored
    send_byte(8'h5A);

    do_reset(2);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_commas(4);
    send_byte(8'h11); send_byte(8'h3C);

    do_reset(2);
    send_commas(3);
    send_byte(8'h22);
    send_commas(4);
    send_byte(8'h44);

    for (int i = 0; i < 7; i++) send_bit(1'(8'h77 >> (7 - i)));
    do_reset(1);
    send_byte(8'h77);
    send_commas(4);
    send_byte(8'h77); send_byte(8'h00); send_byte(8'hFF);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(3, 0) == 0) do_reset($urandom_range(3, 1));
      nb = $urandom_range(12, 0);
      for (int j = 0; j < nb; j++) send_bit(1'($urandom_range(1, 0)));
      send_commas($urandom_range(5, 2));
      nb = $urandom_range(6, 0);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(3, 0) == 0) send_byte(COMMA);
        else send_byte(8'($urandom));
      end
    end

    @(negedge clk_8f);
    @(negedge clk_8f);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
